// File: rtl/nettlp_cmd_pkg.sv
// nettlp_cmd_pkg
// Shared types and constants for the NetTLP command path: the 64-bit
// command/reply FIFO entry layout, opcodes, adapter register addresses,
// register defaults and the command executor state encoding.
package nettlp_cmd_pkg;

  // One FIFO entry: used both for commands (RX) and replies (TX).
  typedef struct packed {
    logic [7:0]  udp_check;
    logic [7:0]  opcode;
    logic [15:0] dwaddr;
    logic [31:0] data;
  } FIFO_NETTLP_CMD_T;

  localparam logic [7:0] NETTLP_OPC_REG_RD  = 8'h10;
  localparam logic [7:0] NETTLP_OPC_REG_WR  = 8'h11;
  localparam logic [7:0] NETTLP_OPC_MAGIC   = 8'h12;
  localparam logic [7:0] NETTLP_OPC_TSTAMP  = 8'h13;
  localparam logic [7:0] NETTLP_OPC_RST_ALL = 8'h14;
  localparam logic [7:0] NETTLP_OPC_ERR     = 8'hFF;

  localparam logic [15:0] ADAPTER_REG_MAGIC        = 16'h0000;
  localparam logic [15:0] ADAPTER_REG_DSTMAC_LOW   = 16'h0001;
  localparam logic [15:0] ADAPTER_REG_DSTMAC_HIGH  = 16'h0002;
  localparam logic [15:0] ADAPTER_REG_SRCMAC_LOW   = 16'h0003;
  localparam logic [15:0] ADAPTER_REG_SRCMAC_HIGH  = 16'h0004;
  localparam logic [15:0] ADAPTER_REG_DSTIP        = 16'h0005;
  localparam logic [15:0] ADAPTER_REG_SRCIP        = 16'h0006;
  localparam logic [15:0] ADAPTER_REG_DSTPORT      = 16'h0007;
  localparam logic [15:0] ADAPTER_REG_SRCPORT      = 16'h0008;
  localparam logic [15:0] ADAPTER_REG_REQUESTER_ID = 16'h0009;

  localparam logic [31:0] NETTLP_MAGIC_VALUE = 32'h4E54_4C50;

  localparam logic [47:0] DEF_DSTMAC  = 48'h0;
  localparam logic [47:0] DEF_SRCMAC  = 48'h0;
  localparam logic [31:0] DEF_DSTIP   = 32'h0;
  localparam logic [31:0] DEF_SRCIP   = 32'h0;
  localparam logic [15:0] DEF_DSTPORT = 16'd14198;
  localparam logic [15:0] DEF_SRCPORT = 16'd14198;
  localparam logic [15:0] DEF_REQID   = 16'h0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_REPLY = 2'd2
  } CMD_EXEC_STATE_T;

endpackage

// File: rtl/nettlp_adapter_regs.sv
// nettlp_adapter_regs
// Adapter register file (MACs, IPs, UDP ports, requester ID).
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_rst_all          synchronous return of every register to its default
//   i_wr_en/i_wr_addr/i_wr_data  write port (MAGIC and unknown addresses ignored)
//   i_rd_addr -> o_rd_data, o_addr_err   combinational read port
//   o_dstmac .. o_reqid  current register values
module nettlp_adapter_regs
  import nettlp_cmd_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rst_all,
  input  logic        i_wr_en,
  input  logic [15:0] i_wr_addr,
  input  logic [31:0] i_wr_data,
  input  logic [15:0] i_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_addr_err,
  output logic [47:0] o_dstmac,
  output logic [47:0] o_srcmac,
  output logic [31:0] o_dstip,
  output logic [31:0] o_srcip,
  output logic [15:0] o_dstport,
  output logic [15:0] o_srcport,
  output logic [15:0] o_reqid
);

  logic [47:0] r_dstmac, r_srcmac;
  logic [31:0] r_dstip, r_srcip;
  logic [15:0] r_dstport, r_srcport, r_reqid;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_rst_all) begin
      r_dstmac  <= DEF_DSTMAC;
      r_srcmac  <= DEF_SRCMAC;
      r_dstip   <= DEF_DSTIP;
      r_srcip   <= DEF_SRCIP;
      r_dstport <= DEF_DSTPORT;
      r_srcport <= DEF_SRCPORT;
      r_reqid   <= DEF_REQID;
    end else if (i_wr_en) begin
      case (i_wr_addr)
        ADAPTER_REG_DSTMAC_LOW:   r_dstmac[31:0]  <= i_wr_data;
        ADAPTER_REG_DSTMAC_HIGH:  r_dstmac[47:32] <= i_wr_data[15:0];
        ADAPTER_REG_SRCMAC_LOW:   r_srcmac[31:0]  <= i_wr_data;
        ADAPTER_REG_SRCMAC_HIGH:  r_srcmac[47:32] <= i_wr_data[15:0];
        ADAPTER_REG_DSTIP:        r_dstip         <= i_wr_data;
        ADAPTER_REG_SRCIP:        r_srcip         <= i_wr_data;
        ADAPTER_REG_DSTPORT:      r_dstport       <= i_wr_data[15:0];
        ADAPTER_REG_SRCPORT:      r_srcport       <= i_wr_data[15:0];
        ADAPTER_REG_REQUESTER_ID: r_reqid         <= i_wr_data[15:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    o_rd_data  = 32'h0;
    o_addr_err = 1'b0;
    case (i_rd_addr)
      ADAPTER_REG_MAGIC:        o_rd_data = NETTLP_MAGIC_VALUE;
      ADAPTER_REG_DSTMAC_LOW:   o_rd_data = r_dstmac[31:0];
      ADAPTER_REG_DSTMAC_HIGH:  o_rd_data = {16'h0, r_dstmac[47:32]};
      ADAPTER_REG_SRCMAC_LOW:   o_rd_data = r_srcmac[31:0];
      ADAPTER_REG_SRCMAC_HIGH:  o_rd_data = {16'h0, r_srcmac[47:32]};
      ADAPTER_REG_DSTIP:        o_rd_data = r_dstip;
      ADAPTER_REG_SRCIP:        o_rd_data = r_srcip;
      ADAPTER_REG_DSTPORT:      o_rd_data = {16'h0, r_dstport};
      ADAPTER_REG_SRCPORT:      o_rd_data = {16'h0, r_srcport};
      ADAPTER_REG_REQUESTER_ID: o_rd_data = {16'h0, r_reqid};
      default:                  o_addr_err = 1'b1;
    endcase
  end

  assign o_dstmac  = r_dstmac;
  assign o_srcmac  = r_srcmac;
  assign o_dstip   = r_dstip;
  assign o_srcip   = r_srcip;
  assign o_dstport = r_dstport;
  assign o_srcport = r_srcport;
  assign o_reqid   = r_reqid;

endmodule

// File: rtl/nettlp_cmd_exec.sv
// nettlp_cmd_exec
// Pops NetTLP command entries, executes them against the adapter register
// file, and pushes exactly one reply entry per command.
// Ports:
//   clk156, eth_rst              clock, synchronous active-high reset
//   cmd_empty/cmd_dout/cmd_rd_en first-word-fall-through command FIFO
//   rep_full/rep_din/rep_wr_en   reply FIFO
//   adapter_*                    current register values
//   cmd_err_cnt                  saturating count of rejected commands
module nettlp_cmd_exec
  import nettlp_cmd_pkg::*;
(
  input  logic        clk156,
  input  logic        eth_rst,
  input  logic        cmd_empty,
  input  logic [63:0] cmd_dout,
  output logic        cmd_rd_en,
  input  logic        rep_full,
  output logic [63:0] rep_din,
  output logic        rep_wr_en,
  output logic [47:0] adapter_dstmac,
  output logic [47:0] adapter_srcmac,
  output logic [31:0] adapter_dstip,
  output logic [31:0] adapter_srcip,
  output logic [15:0] adapter_dstport,
  output logic [15:0] adapter_srcport,
  output logic [15:0] adapter_reqid,
  output logic [15:0] cmd_err_cnt
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  CMD_EXEC_STATE_T  r_state, w_next;
  FIFO_NETTLP_CMD_T r_cmd, r_rep, w_rep;
  logic [31:0]      r_tstamp;
  logic [15:0]      r_err_cnt;
  logic             w_rd_en, w_wr_en, w_reg_wr, w_rst_all, w_err;
  logic [31:0]      w_rd_data;
  logic             w_addr_err;

  nettlp_adapter_regs u_regs (
    .i_clk      (clk156),
    .i_rst      (eth_rst),
    .i_rst_all  (w_rst_all),
    .i_wr_en    (w_reg_wr),
    .i_wr_addr  (r_cmd.dwaddr),
    .i_wr_data  (r_cmd.data),
    .i_rd_addr  (r_cmd.dwaddr),
    .o_rd_data  (w_rd_data),
    .o_addr_err (w_addr_err),
    .o_dstmac   (adapter_dstmac),
    .o_srcmac   (adapter_srcmac),
    .o_dstip    (adapter_dstip),
    .o_srcip    (adapter_srcip),
    .o_dstport  (adapter_dstport),
    .o_srcport  (adapter_srcport),
    .o_reqid    (adapter_reqid)
  );

  always_comb begin
    w_next    = r_state;
    w_rd_en   = 1'b0;
    w_wr_en   = 1'b0;
    w_reg_wr  = 1'b0;
    w_rst_all = 1'b0;
    w_err     = 1'b0;
    w_rep     = r_rep;
    case (r_state)
      ST_IDLE: begin
        if (!cmd_empty) begin
          w_rd_en = 1'b1;
          w_next  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Start from the command so opcode and dwaddr echo unchanged.
        w_rep           = r_cmd;
        w_rep.udp_check = 8'h0;
        w_rep.data      = 32'h0;
        case (r_cmd.opcode)
          NETTLP_OPC_REG_RD: begin
            w_rep.data = w_rd_data;
            w_err      = w_addr_err;
          end
          NETTLP_OPC_REG_WR: begin
            w_reg_wr   = 1'b1;
            w_rep.data = r_cmd.data;
            w_err      = w_addr_err || (r_cmd.dwaddr == ADAPTER_REG_MAGIC);
          end
          NETTLP_OPC_MAGIC:   w_rep.data = NETTLP_MAGIC_VALUE;
          NETTLP_OPC_TSTAMP:  w_rep.data = r_tstamp;
          NETTLP_OPC_RST_ALL: w_rst_all  = 1'b1;
          default: begin
            w_rep.opcode = NETTLP_OPC_ERR;
            w_rep.data   = {24'h0, r_cmd.opcode};
            w_err        = 1'b1;
          end
        endcase
        w_next = ST_REPLY;
      end
      ST_REPLY: begin
        if (!rep_full) begin
          w_wr_en = 1'b1;
          w_next  = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      r_state   <= ST_IDLE;
      r_rep     <= '0;
      r_tstamp  <= 32'h0;
      r_err_cnt <= 16'h0;
    end else begin
      r_state <= w_next;
      r_rep   <= w_rep;
      // RST_ALL takes priority over the free-running increment.
      r_tstamp <= w_rst_all ? 32'h0 : r_tstamp + 32'd1;
      if (w_rst_all)
        r_err_cnt <= 16'h0;
      else if (w_err)
        r_err_cnt <= sat_inc16(r_err_cnt);
    end
  end

  // Command holding register: data only, loaded on the pop.
  always_ff @(posedge clk156) begin
    if (w_rd_en)
      r_cmd <= FIFO_NETTLP_CMD_T'(cmd_dout);
  end

  assign cmd_rd_en   = w_rd_en;
  assign rep_wr_en   = w_wr_en;
  assign rep_din     = r_rep;
  assign cmd_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_nettlp_cmd_exec.sv
module tb_nettlp_cmd_exec;

  logic        clk156 = 1'b0;
  logic        eth_rst = 1'b1;
  logic        cmd_empty = 1'b1;
  logic [63:0] cmd_dout = 64'h0;
  logic        cmd_rd_en;
  logic        rep_full = 1'b0;
  logic [63:0] rep_din;
  logic        rep_wr_en;
  logic [47:0] adapter_dstmac, adapter_srcmac;
  logic [31:0] adapter_dstip, adapter_srcip;
  logic [15:0] adapter_dstport, adapter_srcport, adapter_reqid, cmd_err_cnt;

  always #5 clk156 = ~clk156;

  nettlp_cmd_exec dut (
    .clk156          (clk156),
    .eth_rst         (eth_rst),
    .cmd_empty       (cmd_empty),
    .cmd_dout        (cmd_dout),
    .cmd_rd_en       (cmd_rd_en),
    .rep_full        (rep_full),
    .rep_din         (rep_din),
    .rep_wr_en       (rep_wr_en),
    .adapter_dstmac  (adapter_dstmac),
    .adapter_srcmac  (adapter_srcmac),
    .adapter_dstip   (adapter_dstip),
    .adapter_srcip   (adapter_srcip),
    .adapter_dstport (adapter_dstport),
    .adapter_srcport (adapter_srcport),
    .adapter_reqid   (adapter_reqid),
    .cmd_err_cnt     (cmd_err_cnt)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [47:0] m_dmac, m_smac;
  logic [31:0] m_dip, m_sip;
  logic [15:0] m_dport, m_sport, m_reqid, m_err;
  int unsigned m_base;      // cycle index at which the timestamp read 0
  logic [63:0] in_q[$];     // command FIFO contents
  logic [63:0] exp_q[$];    // expected replies in order

  int unsigned cyc = 0;
  bit          popped, pushed, full_drv = 1'b0;
  int          pops_cnt = 0, push_cnt = 0;
  logic [63:0] last_rep = 64'h0;
  logic [31:0] last_data = 32'h0, prev_data = 32'h0;

  function automatic logic [63:0] mk(input logic [7:0] op, input logic [15:0] a, input logic [31:0] d);
    return {8'h00, op, a, d};
  endfunction

  task automatic model_reset();
    m_dmac = 48'h0; m_smac = 48'h0; m_dip = 32'h0; m_sip = 32'h0;
    m_dport = 16'd14198; m_sport = 16'd14198; m_reqid = 16'h0; m_err = 16'h0;
  endtask

  task automatic bump_err();
    if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
  endtask

  task automatic model_exec(input logic [63:0] c, input int unsigned exec_cyc);
    logic [7:0]  op;
    logic [15:0] a;
    logic [31:0] d, rd;
    op = c[55:48]; a = c[47:32]; d = c[31:0]; rd = 32'h0;
    case (op)
      8'h10: begin
        case (a)
          16'd0: rd = 32'h4E54_4C50;
          16'd1: rd = m_dmac[31:0];
          16'd2: rd = {16'h0, m_dmac[47:32]};
          16'd3: rd = m_smac[31:0];
          16'd4: rd = {16'h0, m_smac[47:32]};
          16'd5: rd = m_dip;
          16'd6: rd = m_sip;
          16'd7: rd = {16'h0, m_dport};
          16'd8: rd = {16'h0, m_sport};
          16'd9: rd = {16'h0, m_reqid};
          default: begin rd = 32'h0; bump_err(); end
        endcase
      end
      8'h11: begin
        rd = d;
        case (a)
          16'd1: m_dmac[31:0]  = d;
          16'd2: m_dmac[47:32] = d[15:0];
          16'd3: m_smac[31:0]  = d;
          16'd4: m_smac[47:32] = d[15:0];
          16'd5: m_dip = d;
          16'd6: m_sip = d;
          16'd7: m_dport = d[15:0];
          16'd8: m_sport = d[15:0];
          16'd9: m_reqid = d[15:0];
          default: bump_err();
        endcase
      end
      8'h12: rd = 32'h4E54_4C50;
      8'h13: rd = exec_cyc - m_base;
      8'h14: begin model_reset(); m_base = exec_cyc + 1; rd = 32'h0; end
      default: begin op = 8'hFF; rd = {24'h0, c[55:48]}; bump_err(); end
    endcase
    exp_q.push_back({8'h00, op, a, rd});
  endtask

  task automatic check_regs();
    check_eq("dstmac", adapter_dstmac, m_dmac);
    check_eq("srcmac", adapter_srcmac, m_smac);
    check_eq("dstip", adapter_dstip, m_dip);
    check_eq("srcip", adapter_srcip, m_sip);
    check_eq("dstport", adapter_dstport, m_dport);
    check_eq("srcport", adapter_srcport, m_sport);
    check_eq("reqid", adapter_reqid, m_reqid);
    check_eq("err_cnt", cmd_err_cnt, m_err);
  endtask

  // One clock: drive FIFO-side inputs after the edge, then observe.
  task automatic step();
    logic [63:0] e;
    @(posedge clk156);
    cyc++;
    #1;
    cmd_empty = (in_q.size() == 0);
    cmd_dout  = cmd_empty ? 64'h0 : in_q[0];
    rep_full  = full_drv;
    #1;
    popped = 1'b0;
    pushed = 1'b0;
    if (!eth_rst) begin
      if (cmd_rd_en) begin
        if (cmd_empty) check_eq("rd_en_while_empty", cmd_empty, 1'b0);
        else begin
          popped = 1'b1;
          pops_cnt++;
          model_exec(in_q.pop_front(), cyc + 1);
        end
      end
      if (rep_wr_en) begin
        pushed = 1'b1;
        push_cnt++;
        if (rep_full) check_eq("wr_en_while_full", rep_full, 1'b0);
        if (exp_q.size() == 0) check_eq("spurious_reply", rep_wr_en, 1'b0);
        else begin
          e = exp_q.pop_front();
          check_eq("reply", rep_din, e);
          last_rep  = rep_din;
          prev_data = last_data;
          last_data = rep_din[31:0];
          check_regs();
        end
      end
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && k < 400) begin
      step();
      k++;
    end
    if (k >= 400) check_eq("drain_timeout", in_q.size() + exp_q.size(), 0);
    repeat (2) step();
  endtask

  task automatic wait_pop();
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!popped && k < 50);
    if (!popped) check_eq("pop_timeout", popped, 1'b1);
  endtask

  initial begin
    model_reset();
    repeat (3) step();
    eth_rst = 1'b0;
    m_base = cyc;
    #1;
    check_eq("rst_rd_en", cmd_rd_en, 1'b0);
    check_eq("rst_wr_en", rep_wr_en, 1'b0);
    check_eq("rst_rep_din", rep_din, 64'h0);
    check_regs();

    // DSTIP write, visible exactly two cycles after the pop
    in_q.push_back(mk(8'h11, 16'h0005, 32'hC0A8_0A01));
    wait_pop();
    step();
    check_eq("dstip_at_p1", adapter_dstip, 32'h0);
    check_eq("rep_not_early", rep_wr_en, 1'b0);
    step();
    check_eq("dstip_at_p2", adapter_dstip, 32'hC0A8_0A01);
    check_eq("dstip_reply", last_rep, 64'h0011_0005_C0A8_0A01);
    drain();

    // Source MAC halves and readback
    in_q.push_back(mk(8'h11, 16'h0004, 32'hDEAD_0A0B));
    in_q.push_back(mk(8'h11, 16'h0003, 32'h0C0D_0E0F));
    in_q.push_back(mk(8'h10, 16'h0004, 32'h0));
    drain();
    check_eq("srcmac_full", adapter_srcmac, 48'h0A0B_0C0D_0E0F);
    check_eq("srcmac_hi_rd", last_data, 32'h0000_0A0B);

    // Magic and back-to-back timestamps
    in_q.push_back(mk(8'h12, 16'h0, 32'h0));
    drain();
    check_eq("magic", last_data, 32'h4E54_4C50);
    in_q.push_back(mk(8'h13, 16'h0, 32'h0));
    in_q.push_back(mk(8'h13, 16'h0, 32'h0));
    drain();
    check_eq("tstamp_delta", last_data - prev_data, 32'd3);

    // Three error cases
    in_q.push_back(mk(8'h11, 16'h0000, 32'h1234_5678));
    in_q.push_back(mk(8'h10, 16'h0020, 32'h0));
    in_q.push_back(mk(8'h33, 16'h0000, 32'h0));
    drain();
    check_eq("err_cnt3", cmd_err_cnt, 16'd3);
    check_eq("err_last_rep", last_rep, 64'h00FF_0000_0000_0033);

    // Reply back-pressure with four queued commands
    full_drv = 1'b1;
    pops_cnt = 0;
    push_cnt = 0;
    in_q.push_back(mk(8'h11, 16'h0009, 32'h0000_BEEF));
    in_q.push_back(mk(8'h10, 16'h0009, 32'h0));
    in_q.push_back(mk(8'h12, 16'h0, 32'h0));
    in_q.push_back(mk(8'h11, 16'h0006, 32'h0A00_0001));
    repeat (10) step();
    check_eq("stall_pops", pops_cnt, 1);
    check_eq("stall_pushes", push_cnt, 0);
    full_drv = 1'b0;
    drain();
    check_eq("post_stall_replies", push_cnt, 4);

    // Non-default ports, then RST_ALL
    in_q.push_back(mk(8'h11, 16'h0007, 32'h0000_1111));
    in_q.push_back(mk(8'h11, 16'h0008, 32'h0000_2222));
    in_q.push_back(mk(8'h14, 16'h0, 32'hFFFF_FFFF));
    drain();
    check_eq("rstall_dport", adapter_dstport, 16'd14198);
    check_eq("rstall_sport", adapter_srcport, 16'd14198);
    check_eq("rstall_err", cmd_err_cnt, 16'h0);
    check_eq("rstall_data", last_data, 32'h0);
    in_q.push_back(mk(8'h13, 16'h0, 32'h0));
    drain();

    // eth_rst while the popped command is in EXEC
    push_cnt = 0;
    in_q.push_back(mk(8'h11, 16'h0007, 32'h0000_5555));
    wait_pop();
    step();
    eth_rst = 1'b1;
    exp_q.delete();
    model_reset();
    step();
    eth_rst = 1'b0;
    m_base = cyc;
    repeat (5) step();
    check_eq("rst_no_reply", push_cnt, 0);
    check_eq("rst_dport", adapter_dstport, 16'd14198);
    in_q.push_back(mk(8'h12, 16'h0, 32'h0));
    step();
    check_eq("idle_after_rst", popped, 1'b1);
    drain();

    // Randomized traffic with random reply back-pressure
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0 && in_q.size() < 8) begin
        logic [7:0] op;
        case ($urandom_range(0, 9))
          0, 1, 2: op = 8'h10;
          3, 4, 5: op = 8'h11;
          6:       op = 8'h12;
          7:       op = 8'h13;
          8:       op = ($urandom_range(0, 3) == 0) ? 8'h14 : 8'h13;
          default: op = 8'($urandom);
        endcase
        in_q.push_back(mk(op, 16'($urandom_range(0, 11)), $urandom));
      end
      full_drv = ($urandom_range(0, 3) == 0);
      step();
    end
    full_drv = 1'b0;
    drain();
    check_regs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
